trigger_scheduler: RTL and testbench

Round-robin scheduler that shares one trigger pulse source between N requesters. Each requester raises a level request; the block grants one at a time, drives a WIDTH-cycle trigger pulse on its behalf, acknowledges with a done strobe, then enforces a DELAY-cycle quiet gap before the next pulse. It sits between the trigger consumers and the single `trigger` line that `signal_generator`-driven logic observes, replacing free-running periodic triggering with on-demand, rate-limited triggering.

---
 rtl/trigger_scheduler.sv | 130 +++++++++++++
 tb/tb_trigger_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : trigger_scheduler
// Purpose  : Round-robin sharing of one trigger pulse source between N
//            requesters. Each grant gets a WIDTH-cycle pulse with a done
//            strobe on its last cycle, followed by a DELAY-cycle quiet gap.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_scheduler #(
  parameter int N     = 4,
  parameter int DELAY = 10,
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [N-1:0] done,
  output logic         trigger,
  output logic         busy
);

  localparam int MAXDW = (DELAY > WIDTH) ? DELAY : WIDTH;
  localparam int CW    = $clog2(MAXDW + 1);
  localparam int LW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] C_WIDTH_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_DELAY_LOAD = CW'(DELAY - 1);
  localparam logic [CW-1:0] C_CNT_ONE    = CW'(1);
  localparam logic [LW-1:0] C_LAST_RST   = LW'(N - 1);
  localparam logic [N-1:0]  C_ONEHOT0    = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [LW-1:0] r_last;

  logic          w_found;
  logic [LW-1:0] w_win;
  logic [N-1:0]  w_onehot;
  logic [N-1:0]  w_launch_done;

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = (int'(r_last) + i) % N;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = LW'(idx);
      end
    end
    w_onehot      = C_ONEHOT0 << w_win;
    // A one-cycle pulse is its own last cycle, so done fires at launch.
    w_launch_done = (WIDTH == 1) ? w_onehot : '0;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= C_LAST_RST;
      grant   <= '0;
      done    <= '0;
      trigger <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_PULSE;
            r_cnt   <= C_WIDTH_LOAD;
            r_last  <= w_win;
            grant   <= w_onehot;
            done    <= w_launch_done;
            trigger <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= S_GAP;
            r_cnt   <= C_DELAY_LOAD;
            grant   <= '0;
            done    <= '0;
            trigger <= 1'b0;
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
            // Raise done for the cycle in which the counter reaches zero.
            done  <= (r_cnt == C_CNT_ONE) ? grant : '0;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            if (w_found) begin
              r_state <= S_PULSE;
              r_cnt   <= C_WIDTH_LOAD;
              r_last  <= w_win;
              grant   <= w_onehot;
              done    <= w_launch_done;
              trigger <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          grant   <= '0;
          done    <= '0;
          trigger <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_scheduler
// Purpose  : Directed self-checking bench for trigger_scheduler, using one
//            instance with WIDTH=1/DELAY=10 and one with WIDTH=3/DELAY=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] grant_a, done_a, grant_b, done_b;
  logic       trigger_a, busy_a, trigger_b, busy_b;

  int errors = 0;
  int checks = 0;

  trigger_scheduler #(.N(4), .DELAY(10), .WIDTH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .grant(grant_a), .done(done_a), .trigger(trigger_a), .busy(busy_a)
  );

  trigger_scheduler #(.N(4), .DELAY(2), .WIDTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .grant(grant_b), .done(done_b), .trigger(trigger_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant_a, done_a, trigger_a, busy_a} !== 10'd0) begin
      errors++;
      $display("FAIL reset_a: got %b want 0", {grant_a, done_a, trigger_a, busy_a});
    end
    checks++;
    if ({grant_b, done_b, trigger_b, busy_b} !== 10'd0) begin
      errors++;
      $display("FAIL reset_b: got %b want 0", {grant_b, done_b, trigger_b, busy_b});
    end
  endtask

  task automatic test_single();
    int bad;
    do_reset();
    req_a = 4'b0100;
    tick();
    checks++;
    if ({trigger_a, busy_a, grant_a, done_a} !== {1'b1, 1'b1, 4'b0100, 4'b0100}) begin
      errors++;
      $display("FAIL single_pulse: trig=%b busy=%b grant=%b done=%b want 1 1 0100 0100",
               trigger_a, busy_a, grant_a, done_a);
    end
    req_a = '0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!(busy_a === 1'b1 && trigger_a === 1'b0 && grant_a === 4'b0 && done_a === 4'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_gap: %0d bad gap cycles, want 0", bad);
    end
    tick();
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b want 0", busy_a);
    end
  endtask

  // Holds req until the final done, checking order, width and 10-cycle gaps.
  task automatic run_rr(input logic [3:0] reqv, input logic [3:0] exp0,
                        input logic [3:0] exp1, input logic [3:0] exp2,
                        input logic [3:0] exp3, input logic [3:0] exp4,
                        input string name);
    logic [3:0] exp_g [5];
    int bad;
    exp_g[0] = exp0; exp_g[1] = exp1; exp_g[2] = exp2; exp_g[3] = exp3; exp_g[4] = exp4;
    do_reset();
    req_a = reqv;
    for (int p = 0; p < 5; p++) begin
      tick();
      checks++;
      if ({trigger_a, grant_a, done_a} !== {1'b1, exp_g[p], exp_g[p]}) begin
        errors++;
        $display("FAIL %s_pulse%0d: trig=%b grant=%b done=%b want 1 %b %b",
                 name, p, trigger_a, grant_a, done_a, exp_g[p], exp_g[p]);
      end
      if (p == 4) req_a = '0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (!(trigger_a === 1'b0 && grant_a === 4'b0 && busy_a === 1'b1)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_gap%0d: %0d bad gap cycles, want 0", name, p, bad);
      end
    end
    tick();
    checks++;
    if ({busy_a, trigger_a} !== 2'b00) begin
      errors++;
      $display("FAIL %s_idle: busy=%b trig=%b want 0 0", name, busy_a, trigger_a);
    end
  endtask

  task automatic test_round_robin();
    run_rr(4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, "rr_all");
  endtask

  task automatic test_alternate();
    run_rr(4'b1010, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, "rr_alt");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_trig [8];
    logic [3:0] exp_done [8];
    int bad;
    exp_trig[0] = 1; exp_trig[1] = 1; exp_trig[2] = 1; exp_trig[3] = 0;
    exp_trig[4] = 0; exp_trig[5] = 1; exp_trig[6] = 1; exp_trig[7] = 1;
    for (int k = 0; k < 8; k++) exp_done[k] = (k == 2 || k == 7) ? 4'b0001 : 4'b0000;
    do_reset();
    req_b = 4'b0001;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 7) req_b = '0;
      checks++;
      if ({trigger_b, done_b, grant_b} !== {exp_trig[k][0], exp_done[k],
                                             exp_trig[k][0] ? 4'b0001 : 4'b0000}) begin
        errors++;
        $display("FAIL wide_cycle%0d: trig=%b done=%b grant=%b want %b %b %b", k,
                 trigger_b, done_b, grant_b, exp_trig[k][0], exp_done[k],
                 exp_trig[k][0] ? 4'b0001 : 4'b0000);
      end
    end
    tick();
    tick();
    tick();
    checks++;
    if ({busy_b, trigger_b} !== 2'b00) begin
      errors++;
      $display("FAIL wide_idle: busy=%b trig=%b want 0 0", busy_b, trigger_b);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_b = 4'b0100;
    tick();
    tick();
    checks++;
    if ({trigger_b, grant_b} !== {1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL arst_pre: trig=%b grant=%b want 1 0100", trigger_b, grant_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant_b, done_b, trigger_b, busy_b} !== 10'd0) begin
      errors++;
      $display("FAIL arst_immediate: got %b want 0", {grant_b, done_b, trigger_b, busy_b});
    end
    req_b = 4'b1001;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({trigger_b, grant_b} !== {1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL arst_first_grant: trig=%b grant=%b want 1 0001", trigger_b, grant_b);
    end
    req_b = '0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_gap_ignore();
    int trig_seen;
    do_reset();
    req_a = 4'b0001;
    tick();
    checks++;
    if (grant_a !== 4'b0001) begin
      errors++;
      $display("FAIL gapign_first: grant=%b want 0001", grant_a);
    end
    req_a = '0;
    trig_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) req_a = 4'b0100;
      if (k == 6) req_a = 4'b0000;
      if (trigger_a === 1'b1) trig_seen++;
    end
    tick();
    if (trigger_a === 1'b1) trig_seen++;
    checks++;
    if (trig_seen != 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL gapign_nopulse: pulses=%0d busy=%b want 0 0", trig_seen, busy_a);
    end
    req_a = 4'b0101;
    tick();
    checks++;
    if ({trigger_a, grant_a} !== {1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL gapign_last: trig=%b grant=%b want 1 0100", trigger_a, grant_a);
    end
    req_a = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_back_to_back();
    test_async_reset();
    test_gap_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
